seq_burst_sched: RTL

Burst scheduler for the eight 8-bit sequence generators (squares, 3^n, triangular, Fibonacci, Pell, Lucas, Padovan, Sylvester).
- Sequences the generators: restarts the chosen generator, single-steps it under a valid/ready stream handshake, and tags each term with channel, index and last flag.
- Runs one selected generator (single mode) or all eight in turn (scan mode).
- Sits between the generator bank and the output mux/stream consumer, replacing the free-running generator clocking.

---
 rtl/seq_burst_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_burst_sched.sv
// Purpose : burst scheduler for the 8-channel sequence generator bank; restarts, single-steps and tags terms.
// Latency : start edge -> one CLEAR cycle -> first beat valid; one term/cycle, one bubble per channel change.
// Backpr. : out_ready low freezes every register and suppresses gen_en, so out_data holds steady.
// Ports   : clk/rst_n; start/abort/mode/sel/len control; busy/done status; gen_clr/gen_en/gen_val to the
//           generator bank; out_valid/out_ready/out_data/out_chan/out_idx/out_last stream to the consumer.
module seq_burst_sched #(
  parameter int W   = 8,
  parameter int NCH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [2:0]       sel,
  input  logic [7:0]       len,
  output logic             busy,
  output logic             done,
  output logic [NCH-1:0]   gen_clr,
  output logic [NCH-1:0]   gen_en,
  input  logic [NCH*W-1:0] gen_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [2:0]       out_chan,
  output logic [7:0]       out_idx,
  output logic             out_last
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_EMIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [7:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  len_q, len_d;

  logic        emit;
  logic        xfer;
  logic        final_term;
  logic        last_ch;

  assign emit       = (state_q == S_EMIT);
  assign xfer       = emit && out_ready;
  // len_q is never 0 while in EMIT, so the subtraction cannot underflow there.
  assign final_term = (idx_q == (len_q - 8'd1));
  assign last_ch    = !mode_q || (ch_q == 3'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      sel_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          sel_d   = sel;
          len_d   = len;
          ch_d    = mode ? 3'd0 : sel;
          idx_d   = '0;
          state_d = (len != 8'd0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: state_d = S_EMIT;
      S_EMIT: begin
        if (out_ready) begin
          if (!final_term) begin
            idx_d = idx_q + 8'd1;
          end else if (last_ch) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 3'd1;
            idx_d   = '0;
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; a beat handshaken this cycle has already been consumed.
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // Status and tag outputs decode only registered state, so they change only on clock edges.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = emit;
  assign out_chan  = ch_q;
  assign out_idx   = idx_q;
  assign out_last  = emit && final_term && last_ch;
  assign gen_clr   = (state_q == S_CLEAR) ? (NCH'(1) << ch_q) : '0;
  // The final term of a channel is not stepped: the generator is reloaded before reuse anyway.
  assign gen_en    = (xfer && !final_term) ? (NCH'(1) << ch_q) : '0;
  assign out_data  = gen_val[ch_q*W +: W];

endmodule
